fp_add_sub: RTL and testbench
=============================

// Module: fp_add_sub
// PURPOSE
// - IEEE-754 binary32 adder/subtractor: the FP add/sub execution unit of the RISC-V FP datapath.
// - Takes two unpacked operands plus an add/sub opcode; returns a packed result and a result-class error code.
// - Results are bit-exact with a native single-precision add/sub: round-to-nearest-even, full subnormal support.
// PARAMETERS
// - none; field widths (1/8/23) are fixed constants in addpkg.
// PORTS
// - clk     in   1   clock; single clock domain, rising edge.
// - rst_n   in   1   reset; synchronous, active-low.
// - sign1   in   1   operand 1 sign.
// - exp1    in   8   operand 1 biased exponent.
// - sig1    in   23  operand 1 fraction, hidden bit excluded.
// - sign2   in   1   operand 2 sign.
// - exp2    in   8   operand 2 biased exponent.
// - sig2    in   23  operand 2 fraction.
// - opcode  in   1   0 = op1 + op2; 1 = op1 - op2.
// - fp_out  out  32  packed result {sign, exp[7:0], frac[22:0]}.
// - err_o   out  3   result class, type addpkg::o_err_t.
// BEHAVIOUR
// - Reset: when rst_n = 0 at a rising edge, fp_out <= 32'h0 and err_o <= NO_ERR.
// - Datapath is combinational into one output register. Inputs sampled at edge N give the result at edge N+1; no handshake.
// - A new operation can start every cycle.
// - Subtraction: invert sign2, then perform the add.
// - Special cases, checked first:
//   - Either operand NaN -> 32'h7FC00000, INVALID.
//   - (+inf) + (-inf) -> 32'h7FC00000, INVALID.
//   - Otherwise an inf operand -> inf of that sign, OVERFLOW.
// - Hidden bit: 1 if exp != 0; 0 for subnormals, which use effective exponent 1.
// - Alignment:
//   - Swap so op A has the larger magnitude.
//   - Right-shift B's 24-bit significand within a 27-bit field {sig, guard, round, sticky}.
//   - Sticky ORs every bit shifted out; shifts of 26 or more leave only sticky.
// - Add or subtract magnitudes in 28 bits. Result sign = sign of A.
// - Normalisation:
//   - Carry out -> shift right 1 (sticky preserved), exponent + 1.
//   - Otherwise left-shift by the leading-zero count, limited so the exponent does not go below 1; stopping at the limit yields a subnormal (exp field 0).
// - Rounding: RNE on guard/round/sticky. A significand carry from rounding bumps the exponent.
// - Exponent reaching 255 -> +/-inf (32'h7F800000 / 32'hFF800000), OVERFLOW.
// - Exact-zero result:
//   - -0 only when both effective operands are -0; otherwise +0.
//   - Example: x + (-x) = +0.
// - err_o by result class, evaluated in priority order:
//   - NaN -> INVALID.
//   - inf -> OVERFLOW.
//   - Nonzero subnormal -> UNDERFLOW.
//   - Otherwise NO_ERR.
// STRUCTURE
// - addpkg holds:
//   - typedef enum logic [2:0] o_err_t {NO_ERR=0, OVERFLOW=1, UNDERFLOW=2, INVALID=3}.
//   - Constants EXP_W=8, FRAC_W=23, BIAS=127, QNAN=32'h7FC00000.
// - Sub-module fp_lzc: 28-bit leading-zero counter for the normaliser.
// - Internal stages: swap/compare, align, add, normalise, round, pack.
// TESTING
// - Every operation holds its inputs for 2 cycles before fp_out/err_o are checked.
// - Reset with rst_n = 0 -> fp_out = 0, err_o = NO_ERR.
// - 0x40000000 + 0x40000000 (2.0 + 2.0), opcode 0 -> 0x40800000, NO_ERR.
// - 0x3F800000 - 0x3F800000, opcode 1 -> 0x00000000, NO_ERR.
// - 0x7F800000 - 0x7F800000 -> 0x7FC00000, INVALID.
// - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, OVERFLOW.
// - 0x00000001 + 0x00000001 -> 0x00000002, UNDERFLOW.
// - 0x3F800000 + 0x33800000 -> 0x3F800000 (tie rounds to even).
// - 0x3F800000 + 0x33800001 -> 0x3F800001.
// - Sweep: all operand-class pairs {zero, denorm, normal, inf, NaN} x all 8 {opcode, sign1, sign2} combinations; compare against a shortreal model.

Source files
------------

// File: rtl/addpkg.sv
// Shared types and constants for the binary32 add/sub unit.
package addpkg;

  typedef enum logic [2:0] {
    NO_ERR    = 3'd0,
    OVERFLOW  = 3'd1,
    UNDERFLOW = 3'd2,
    INVALID   = 3'd3
  } o_err_t;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned BIAS   = 127;
  localparam int unsigned EXP_MAX = 2 * BIAS + 1;
  localparam logic [31:0] QNAN   = 32'h7FC00000;

  function automatic logic is_nan(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
    return (e == 8'hFF) && (f != '0);
  endfunction

  function automatic logic is_inf(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
    return (e == 8'hFF) && (f == '0);
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// 28-bit leading-zero counter; an all-zero input reports 28.
module fp_lzc (
  input  logic [27:0] in_bits,
  output logic [4:0]  count
);

  // Ascending scan: the highest set bit is the last to write count.
  always_comb begin
    count = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (in_bits[i]) count = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fp_add_sub.sv
// Binary32 adder/subtractor, RNE with subnormals: combinational datapath into one output register.
module fp_add_sub
  import addpkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sign1,
  input  logic [EXP_W-1:0]  exp1,
  input  logic [FRAC_W-1:0] sig1,
  input  logic              sign2,
  input  logic [EXP_W-1:0]  exp2,
  input  logic [FRAC_W-1:0] sig2,
  input  logic              opcode,
  output logic [31:0]       fp_out,
  output o_err_t            err_o
);

  logic              sign2_eff;
  logic              nan1, nan2, inf1, inf2;
  logic              op1_big;
  logic              sa, sb, eff_sub;
  logic [EXP_W-1:0]  ea_raw, eb_raw, ea, eb, diff;
  logic [FRAC_W-1:0] fa, fb;
  logic [23:0]       ma, mb;
  logic [4:0]        shamt;
  logic [26:0]       b_ext, b_shift, b_lost, b_al;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic [7:0]        lsh, lim, sh;
  logic [26:0]       norm;
  logic [9:0]        exp_n, exp_r;
  logic              round_up;
  logic [24:0]       mant_r;
  logic [22:0]       frac_r;
  logic [31:0]       res_d;
  o_err_t            err_d;

  // Swap/compare: raw {exp, frac} ordering is magnitude ordering.
  always_comb begin
    sign2_eff = sign2 ^ opcode;
    nan1      = is_nan(exp1, sig1);
    nan2      = is_nan(exp2, sig2);
    inf1      = is_inf(exp1, sig1);
    inf2      = is_inf(exp2, sig2);
    op1_big   = {exp1, sig1} >= {exp2, sig2};
    if (op1_big) begin
      sa = sign1;     ea_raw = exp1; fa = sig1;
      sb = sign2_eff; eb_raw = exp2; fb = sig2;
    end else begin
      sa = sign2_eff; ea_raw = exp2; fa = sig2;
      sb = sign1;     eb_raw = exp1; fb = sig1;
    end
    eff_sub = sa ^ sb;
    ea      = (ea_raw == '0) ? 8'd1 : ea_raw;
    eb      = (eb_raw == '0) ? 8'd1 : eb_raw;
    ma      = {ea_raw != '0, fa};
    mb      = {eb_raw != '0, fb};
    diff    = ea - eb;
  end

  // Align B into {sig, guard, round, sticky}; every bit shifted out folds into sticky.
  always_comb begin
    shamt   = (diff >= 8'd27) ? 5'd27 : diff[4:0];
    b_ext   = {mb, 3'b000};
    b_shift = b_ext >> shamt;
    b_lost  = b_ext & ~({27{1'b1}} << shamt);
    b_al    = {b_shift[26:1], b_shift[0] | (|b_lost)};
    sum     = eff_sub ? ({1'b0, ma, 3'b000} - {1'b0, b_al})
                      : ({1'b0, ma, 3'b000} + {1'b0, b_al});
  end

  fp_lzc u_lzc (
    .in_bits (sum),
    .count   (lz)
  );

  // Normalise, then round to nearest even on guard/round/sticky.
  always_comb begin
    lsh = {3'b000, lz} - 8'd1;
    lim = ea - 8'd1;
    sh  = (lsh < lim) ? lsh : lim;
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = {2'b00, ea} + 10'd1;
    end else begin
      norm  = sum[26:0] << sh;
      exp_n = {2'b00, ea} - {2'b00, sh};
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[26:3]} + {24'd0, round_up};
    // No hidden bit after rounding means the result stayed subnormal.
    if (mant_r[24])      exp_r = exp_n + 10'd1;
    else if (mant_r[23]) exp_r = exp_n;
    else                 exp_r = 10'd0;
    frac_r = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
  end

  // Pack with special-case priority.
  always_comb begin
    res_d = 32'h0;
    err_d = NO_ERR;
    if (nan1 || nan2 || (inf1 && inf2 && (sign1 != sign2_eff))) begin
      res_d = QNAN;
      err_d = INVALID;
    end else if (inf1) begin
      res_d = {sign1, 8'hFF, 23'd0};
      err_d = OVERFLOW;
    end else if (inf2) begin
      res_d = {sign2_eff, 8'hFF, 23'd0};
      err_d = OVERFLOW;
    end else if (sum == '0) begin
      res_d = {sa & sb, 31'd0};
    end else if (exp_r >= 10'(EXP_MAX)) begin
      res_d = {sa, 8'hFF, 23'd0};
      err_d = OVERFLOW;
    end else begin
      res_d = {sa, exp_r[7:0], frac_r};
      if (exp_r == 10'd0) err_d = UNDERFLOW;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fp_out <= 32'h0;
      err_o  <= NO_ERR;
    end else begin
      fp_out <= res_d;
      err_o  <= err_d;
    end
  end

endmodule

// File: tb/tb_fp_add_sub.sv
// Scoreboarded bench for fp_add_sub: directed vectors plus an operand-class sweep.
module tb_fp_add_sub;
  import addpkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sign1, sign2, opcode;
  logic [7:0]  exp1, exp2;
  logic [22:0] sig1, sig2;
  logic [31:0] fp_out;
  o_err_t      err_o;

  typedef struct {
    logic [31:0] val;
    o_err_t      err;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  event        sample_ev;
  logic [31:0] mag [5];

  always #5 clk = ~clk;

  fp_add_sub dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sign1  (sign1),
    .exp1   (exp1),
    .sig1   (sig1),
    .sign2  (sign2),
    .exp2   (exp2),
    .sig2   (sig2),
    .opcode (opcode),
    .fp_out (fp_out),
    .err_o  (err_o)
  );

  task automatic push_exp(input string name, input logic [31:0] v, input o_err_t e);
    exp_t x;
    x.val  = v;
    x.err  = e;
    x.name = name;
    sb_q.push_back(x);
  endtask

  // Inputs held across two rising edges, then the monitor is told to sample.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] v, input o_err_t e);
    @(negedge clk);
    sign1  = a[31]; exp1 = a[30:23]; sig1 = a[22:0];
    sign2  = b[31]; exp2 = b[30:23]; sig2 = b[22:0];
    opcode = op;
    push_exp(name, v, e);
    @(posedge clk);
    @(posedge clk);
    #1;
    ->sample_ev;
  endtask

  // Class model: 0 zero, 1 min subnormal, 2 one, 3 inf, 4 NaN.
  function automatic void class_model(input int ci, input logic s1, input int cj, input logic s2,
                                      output logic [31:0] v, output o_err_t e);
    logic [31:0] m;
    v = 32'h0;
    e = NO_ERR;
    if (ci == 4 || cj == 4) begin
      v = QNAN; e = INVALID;
    end else if (ci == 3 && cj == 3) begin
      if (s1 != s2) begin v = QNAN; e = INVALID; end
      else begin v = {s1, 31'h7F800000}; e = OVERFLOW; end
    end else if (ci == 3) begin
      v = {s1, 31'h7F800000}; e = OVERFLOW;
    end else if (cj == 3) begin
      v = {s2, 31'h7F800000}; e = OVERFLOW;
    end else if (ci != cj) begin
      m = (ci > cj) ? mag[ci] : mag[cj];
      v = {(ci > cj) ? s1 : s2, m[30:0]};
      e = ((ci > cj ? ci : cj) == 1) ? UNDERFLOW : NO_ERR;
    end else if (s1 != s2) begin
      v = 32'h0; e = NO_ERR;
    end else begin
      case (ci)
        0:       begin v = {s1, 31'h0};        e = NO_ERR;    end
        1:       begin v = {s1, 31'h2};        e = UNDERFLOW; end
        default: begin v = {s1, 31'h40000000}; e = NO_ERR;    end
      endcase
    end
  endfunction

  initial begin : monitor
    exp_t x;
    forever begin
      @(sample_ev);
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_sample: got fp_out=%h err=%0d, no expectation queued",
                 fp_out, err_o);
      end else begin
        x = sb_q.pop_front();
        if (fp_out !== x.val || err_o !== x.err)  begin
          failures++;
          $display("FAIL %s: got fp_out=%h err=%0d, want fp_out=%h err=%0d",
                   x.name, fp_out, err_o, x.val, x.err);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] a, b, v;
    o_err_t      e;
    logic        op, s1, s2;
    mag[0] = 32'h00000000;
    mag[1] = 32'h00000001;
    mag[2] = 32'h3F800000;
    mag[3] = 32'h7F800000;
    mag[4] = 32'h7F800001;

    rst_n = 1'b0;
    sign1 = 1'b1; exp1 = 8'h80; sig1 = 23'h1;
    sign2 = 1'b0; exp2 = 8'h80; sig2 = 23'h1;
    opcode = 1'b0;
    push_exp("reset", 32'h0, NO_ERR);
    @(posedge clk);
    @(posedge clk);
    #1;
    ->sample_ev;
    @(negedge clk);
    rst_n = 1'b1;

    run_op("two_plus_two",   32'h40000000, 32'h40000000, 1'b0, 32'h40800000, NO_ERR);
    run_op("one_minus_one",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, NO_ERR);
    run_op("inf_minus_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, INVALID);
    run_op("max_plus_max",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, OVERFLOW);
    run_op("denorm_sum",     32'h00000001, 32'h00000001, 1'b0, 32'h00000002, UNDERFLOW);
    run_op("tie_to_even",    32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, NO_ERR);
    run_op("above_tie",      32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, NO_ERR);
    run_op("cancel_to_ulp",  32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, NO_ERR);
    run_op("normal_to_sub",  32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, UNDERFLOW);
    run_op("big_tie_even",   32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, NO_ERR);
    run_op("big_tie_odd",    32'h4B800000, 32'h40400000, 1'b0, 32'h4B800002, NO_ERR);
    run_op("neg_zero_sum",   32'h80000000, 32'h00000000, 1'b1, 32'h80000000, NO_ERR);
    run_op("sub_swap_sign",  32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, NO_ERR);

    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        for (int k = 0; k < 8; k++) begin
          op = k[2];
          s1 = k[1];
          s2 = k[0];
          a  = {s1, mag[i][30:0]};
          b  = {s2, mag[j][30:0]};
          class_model(i, s1, j, s2 ^ op, v, e);
          run_op($sformatf("sweep_c%0d_c%0d_k%0d", i, j, k), a, b, op, v, e);
        end
      end
    end

    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
